// File: rtl/sprite_mover_engine_if.sv
// Pixel-write and control bundle between a sprite controller and the sprite
// mover engine. The master drives move/direction/clear requests and the sprite
// colour. The slave (the engine) drives the pixel-write port and busy.
interface sprite_mover_engine_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic               move;
  logic               ld_dir;
  logic [1:0]         dir;
  logic [1:0]         axis_en;
  logic               clear;
  logic [COLOR_W-1:0] spr_color;
  logic               plot;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               busy;

  modport master (
    output move, ld_dir, dir, axis_en, clear, spr_color,
    input  plot, x, y, color, busy
  );

  modport slave (
    input  move, ld_dir, dir, axis_en, clear, spr_color,
    output plot, x, y, color, busy
  );
endinterface

// File: rtl/sprite_mover_engine.sv
// Sprite mover engine: holds one rectangular sprite position. Each move
// request erases the sprite, steps and clamps the position, then redraws it.
// A clear request floods the whole screen with the background colour and then
// redraws the sprite at its start position. One pixel is written per clock.
module sprite_mover_engine #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int SPR_W    = 4,
  parameter int SPR_H    = 4,
  parameter int STEP     = 1,
  parameter int START_X  = 0,
  parameter int START_Y  = 0,
  parameter int BG_COLOR = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  sprite_mover_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ERASE, S_UPDATE, S_DRAW, S_CLEAR
  } state_e;

  localparam logic [X_W-1:0]     START_XV   = X_W'(START_X);
  localparam logic [Y_W-1:0]     START_YV   = Y_W'(START_Y);
  localparam logic [X_W-1:0]     SPR_X_LAST = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0]     SPR_Y_LAST = Y_W'(SPR_H - 1);
  localparam logic [X_W-1:0]     SCR_X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]     SCR_Y_LAST = Y_W'(SCREEN_H - 1);
  // One extra bit on the step arithmetic so the clamp compare cannot wrap.
  localparam logic [X_W:0]       X_MAX      = (X_W+1)'(SCREEN_W - SPR_W);
  localparam logic [Y_W:0]       Y_MAX      = (Y_W+1)'(SCREEN_H - SPR_H);
  localparam logic [X_W:0]       X_STEP     = (X_W+1)'(STEP);
  localparam logic [Y_W:0]       Y_STEP     = (Y_W+1)'(STEP);
  localparam logic [COLOR_W-1:0] BG         = COLOR_W'(BG_COLOR);

  state_e             state_q, state_d;
  logic [X_W-1:0]     pos_x_q, pos_x_d;
  logic [Y_W-1:0]     pos_y_q, pos_y_d;
  logic [X_W-1:0]     cx_q, cx_d;
  logic [Y_W-1:0]     cy_q, cy_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         axn_q, axn_d;
  logic               move_q, clear_q;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               busy_q, busy_d;

  logic               move_rise, clear_rise;
  logic [X_W:0]       x_inc, x_dec;
  logic [Y_W:0]       y_inc, y_dec;

  assign move_rise  = bus.move  & ~move_q;
  assign clear_rise = bus.clear & ~clear_q;

  // Next state, position/counter update and the registered pixel-port values.
  // The _d counters name the pixel that will be on the port next cycle, so
  // outputs registered from them line up with the state they belong to.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_d   = bus.ld_dir ? bus.dir     : dir_q;
    axn_d   = bus.ld_dir ? bus.axis_en : axn_q;
    x_inc   = {1'b0, pos_x_q} + X_STEP;
    x_dec   = {1'b0, pos_x_q} - X_STEP;
    y_inc   = {1'b0, pos_y_q} + Y_STEP;
    y_dec   = {1'b0, pos_y_q} - Y_STEP;

    unique case (state_q)
      S_INIT: begin
        state_d = S_DRAW;
        cx_d    = '0;
        cy_d    = '0;
      end
      S_IDLE: begin
        if (clear_rise) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (move_rise) begin
          state_d = S_ERASE;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      S_ERASE, S_DRAW: begin
        if (cx_q == SPR_X_LAST) begin
          cx_d = '0;
          if (cy_q == SPR_Y_LAST) begin
            cy_d    = '0;
            state_d = (state_q == S_ERASE) ? S_UPDATE : S_IDLE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_UPDATE: begin
        state_d = S_DRAW;
        cx_d    = '0;
        cy_d    = '0;
        if (axn_q[1]) begin
          if (dir_q[1]) pos_x_d = (x_inc > X_MAX) ? X_MAX[X_W-1:0] : x_inc[X_W-1:0];
          else          pos_x_d = ({1'b0, pos_x_q} < X_STEP) ? '0 : x_dec[X_W-1:0];
        end
        if (axn_q[0]) begin
          if (dir_q[0]) pos_y_d = ({1'b0, pos_y_q} < Y_STEP) ? '0 : y_dec[Y_W-1:0];
          else          pos_y_d = (y_inc > Y_MAX) ? Y_MAX[Y_W-1:0] : y_inc[Y_W-1:0];
        end
      end
      S_CLEAR: begin
        if (cx_q == SCR_X_LAST) begin
          cx_d = '0;
          if (cy_q == SCR_Y_LAST) begin
            cy_d    = '0;
            state_d = S_DRAW;
            pos_x_d = START_XV;
            pos_y_d = START_YV;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    plot_d  = state_d inside {S_ERASE, S_DRAW, S_CLEAR};
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    if (plot_d) begin
      x_d     = (state_d == S_CLEAR) ? cx_d : pos_x_d + cx_d;
      y_d     = (state_d == S_CLEAR) ? cy_d : pos_y_d + cy_d;
      color_d = (state_d == S_DRAW) ? bus.spr_color : BG;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, position, latched direction, edge-detect and output registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      pos_x_q <= START_XV;
      pos_y_q <= START_YV;
      cx_q    <= '0;
      cy_q    <= '0;
      dir_q   <= '0;
      axn_q   <= '0;
      move_q  <= 1'b0;
      clear_q <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_q   <= dir_d;
      axn_q   <= axn_d;
      move_q  <= bus.move;
      clear_q <= bus.clear;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.plot  = plot_q;
  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.busy  = busy_q;

endmodule
